// File: rtl/cpu_defs.sv
// Shared definitions for the data-memory port arbiter: read-return owner codes,
// the byte-enable pattern that marks a read, and the arbiter's local enums.
package cpu_defs;

  localparam logic [1:0] RD_NONE     = 2'd0;
  localparam logic [1:0] RD_CPU      = 2'd1;
  localparam logic [1:0] RD_DEV      = 2'd2;
  localparam logic [3:0] BYTEEN_READ = 4'b0000;

  typedef enum logic [1:0] {
    OWN_NONE = RD_NONE,
    OWN_CPU  = RD_CPU,
    OWN_DEV  = RD_DEV
  } rd_owner_t;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_CPU,
    ISS_DEV
  } issue_t;

endpackage

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the CPU M stage and one device
// requester; CPU has fixed priority, bounded by a device starvation counter.
module dm_port_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_byteen,
  input  logic              cpu_cancel,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [31:0]       dev_wdata,
  input  logic [3:0]        dev_byteen,
  output logic              dev_gnt,
  output logic              dev_rvalid,
  output logic [31:0]       dev_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_byteen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  logic       cpu_live;
  issue_t     issue;
  logic [3:0] starve_cnt;
  rd_owner_t  rd_owner, rd_owner_nxt;
  logic [31:0] cpu_rdata_q, dev_rdata_q;

  assign cpu_live = cpu_req & ~cpu_cancel;

  // Issue decision; nothing issues while reset is asserted so outputs stay quiet.
  always_comb begin
    issue = ISS_IDLE;
    if (reset_n) begin
      if (dev_req && (!cpu_live || starve_cnt == STARVE_LIM))
        issue = ISS_DEV;
      else if (cpu_live)
        issue = ISS_CPU;
    end
  end

  assign cpu_stall = cpu_live & reset_n & (issue != ISS_CPU);
  assign dev_gnt   = (issue == ISS_DEV);

  always_comb begin
    mem_en     = 1'b0;
    mem_byteen = BYTEEN_READ;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (issue)
      ISS_CPU: begin
        mem_en     = 1'b1;
        mem_byteen = cpu_we ? cpu_byteen : BYTEEN_READ;
        mem_addr   = word_align(cpu_addr);
        mem_wdata  = cpu_wdata;
      end
      ISS_DEV: begin
        mem_en     = 1'b1;
        mem_byteen = dev_we ? dev_byteen : BYTEEN_READ;
        mem_addr   = word_align(dev_addr);
        mem_wdata  = dev_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_cnt <= '0;
    else if (!dev_req || dev_gnt)
      starve_cnt <= '0;
    else if (starve_cnt != STARVE_LIM)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Read-return owner: remembers who issued a load so the next cycle's
  // mem_rdata is steered to the right requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_owner <= OWN_NONE;
    else          rd_owner <= rd_owner_nxt;
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (issue == ISS_CPU && !cpu_we)
      rd_owner_nxt = OWN_CPU;
    else if (issue == ISS_DEV && !dev_we)
      rd_owner_nxt = OWN_DEV;
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dev_rvalid = (rd_owner == OWN_DEV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dev_rvalid) dev_rdata_q <= mem_rdata;
    end
  end

  // Return data passes straight through in the return cycle, then holds.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dev_rdata = dev_rvalid ? mem_rdata : dev_rdata_q;

endmodule
